// File: rtl/datapath_mem_wb_stage.sv
// Memory-access stage with little-endian byte/half/word RAM and the MEM/WB pipeline register.
// Latency: 1 cycle from the EX/MEM bundle to the memwb_* outputs; loads read the RAM combinationally.
// Backpressure: stall freezes MEM/WB and blocks RAM writes; flush inserts a bubble and also blocks writes.
module datapath_mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              resetGral,
  input  logic [DATA_W-1:0] exmem_alu_result,
  input  logic [DATA_W-1:0] exmem_store_data,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic              exmem_reg_write,
  input  logic              exmem_mem_to_reg,
  input  logic              exmem_mem_read,
  input  logic              exmem_mem_write,
  input  logic [1:0]        exmem_size,
  input  logic              exmem_unsigned,
  input  logic              exmem_overflow,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_W-1:0]  memwb_rd,
  output logic              memwb_reg_write,
  output logic [DATA_W-1:0] wb_data,
  output logic              memwb_misaligned,
  output logic              memwb_overflow
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [REG_W-1:0]  r_rd;
  logic              r_reg_write;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_misaligned;
  logic              r_overflow;

  logic [ADDR_W-1:0] w_idx;
  logic [1:0]        w_lane;
  logic [DATA_W-1:0] w_word;
  logic              w_mem_op;
  logic              w_misaligned;
  logic              w_we;
  logic              w_reg_write;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_wb_next;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  // Upper address bits are dropped on purpose so out-of-range addresses wrap around the RAM.
  assign w_idx    = exmem_alu_result[ADDR_W+1:2];
  assign w_lane   = exmem_alu_result[1:0];
  assign w_word   = r_mem[w_idx];
  assign w_mem_op = exmem_mem_read | exmem_mem_write;

  // Size 2'b11 is treated as a word, so size[1] alone identifies a word access.
  assign w_misaligned = w_mem_op &
                        (((exmem_size == 2'b01) & w_lane[0]) |
                         (exmem_size[1] & (w_lane != 2'b00)));

  // A faulting instruction must never commit architectural state.
  assign w_we        = exmem_mem_write & ~w_misaligned & ~exmem_overflow & ~stall & ~flush;
  assign w_reg_write = exmem_reg_write & ~w_misaligned & ~exmem_overflow;

  assign w_byte    = w_word[{w_lane, 3'b000} +: 8];
  assign w_half    = w_word[{w_lane[1], 4'b0000} +: 16];
  assign w_wb_next = exmem_mem_to_reg ? w_load : exmem_alu_result;

  // Extract the addressed lane and sign/zero-extend it.
  always_comb begin
    w_load = w_word;
    case (exmem_size)
      2'b00:   w_load = exmem_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                       : {{(DATA_W-8){w_byte[7]}}, w_byte};
      2'b01:   w_load = exmem_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                       : {{(DATA_W-16){w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Merge the store data into the current word so untouched lanes keep their value.
  always_comb begin
    w_wdata = w_word;
    case (exmem_size)
      2'b00:   w_wdata[{w_lane, 3'b000} +: 8]     = exmem_store_data[7:0];
      2'b01:   w_wdata[{w_lane[1], 4'b0000} +: 16] = exmem_store_data[15:0];
      default: w_wdata = exmem_store_data;
    endcase
  end

  // Data RAM: cleared on reset, one read-modify-write per legal store.
  always_ff @(posedge clock) begin
    if (resetGral) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  // MEM/WB register: reset > flush (bubble) > stall (hold) > load new bundle.
  always_ff @(posedge clock) begin
    if (resetGral || flush) begin
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_wb_data    <= '0;
      r_misaligned <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (!stall) begin
      r_rd         <= exmem_rd;
      r_reg_write  <= w_reg_write;
      r_wb_data    <= w_wb_next;
      r_misaligned <= w_misaligned;
      r_overflow   <= exmem_overflow;
    end
  end

  assign memwb_rd         = r_rd;
  assign memwb_reg_write  = r_reg_write;
  assign wb_data          = r_wb_data;
  assign memwb_misaligned = r_misaligned;
  assign memwb_overflow   = r_overflow;

endmodule
